// File: rtl/procyon_wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: N masters share one slave port,
// ownership held for a whole cyc interval so bursts are never split.
module procyon_wb_arbiter #(
  parameter  int OPTN_NUM_MASTERS   = 2,
  parameter  int OPTN_WB_DATA_WIDTH = 32,
  parameter  int OPTN_WB_ADDR_WIDTH = 32,
  localparam int WB_DATA_SIZE  = OPTN_WB_DATA_WIDTH / 8,
  localparam int GNT_IDX_WIDTH = $clog2(OPTN_NUM_MASTERS)
) (
  input  logic                                         i_wb_clk,
  input  logic                                         i_wb_rst,
  input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_wb_cyc,
  input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_wb_stb,
  input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_wb_we,
  input  logic [OPTN_NUM_MASTERS*3-1:0]                i_m_wb_cti,
  input  logic [OPTN_NUM_MASTERS*2-1:0]                i_m_wb_bte,
  input  logic [OPTN_NUM_MASTERS*WB_DATA_SIZE-1:0]     i_m_wb_sel,
  input  logic [OPTN_NUM_MASTERS*OPTN_WB_ADDR_WIDTH-1:0] i_m_wb_addr,
  input  logic [OPTN_NUM_MASTERS*OPTN_WB_DATA_WIDTH-1:0] i_m_wb_data,
  output logic [OPTN_NUM_MASTERS-1:0]                  o_m_wb_ack,
  output logic [OPTN_WB_DATA_WIDTH-1:0]                o_m_wb_data,
  output logic                                         o_s_wb_cyc,
  output logic                                         o_s_wb_stb,
  output logic                                         o_s_wb_we,
  output logic [2:0]                                   o_s_wb_cti,
  output logic [1:0]                                   o_s_wb_bte,
  output logic [WB_DATA_SIZE-1:0]                      o_s_wb_sel,
  output logic [OPTN_WB_ADDR_WIDTH-1:0]                o_s_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]                o_s_wb_data,
  input  logic                                         i_s_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]                i_s_wb_data,
  output logic                                         o_grant_valid,
  output logic [GNT_IDX_WIDTH-1:0]                     o_grant_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                   state_q;
  logic                     grant_valid_q;
  logic [GNT_IDX_WIDTH-1:0] grant_idx_q;
  logic [GNT_IDX_WIDTH-1:0] rr_ptr_q;

  logic                     win_found;
  logic [GNT_IDX_WIDTH-1:0] win_idx;
  logic [GNT_IDX_WIDTH-1:0] next_ptr;
  logic                     owner_cyc;

  function automatic logic [GNT_IDX_WIDTH-1:0] wrap_add(
    input logic [GNT_IDX_WIDTH-1:0] base,
    input int                       off
  );
    int s;
    s = int'(base) + off;
    if (s >= OPTN_NUM_MASTERS) s = s - OPTN_NUM_MASTERS;
    return s[GNT_IDX_WIDTH-1:0];
  endfunction

  // Scan downward so the requester closest to rr_ptr is assigned last
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = OPTN_NUM_MASTERS-1; i >= 0; i--) begin
      if (i_m_wb_cyc[wrap_add(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign next_ptr = wrap_add(grant_idx_q, 1);

  always_comb begin
    owner_cyc   = 1'b0;
    o_s_wb_stb  = 1'b0;
    o_s_wb_we   = 1'b0;
    o_s_wb_cti  = '0;
    o_s_wb_bte  = '0;
    o_s_wb_sel  = '0;
    o_s_wb_addr = '0;
    o_s_wb_data = '0;
    o_m_wb_ack  = '0;
    for (int m = 0; m < OPTN_NUM_MASTERS; m++) begin
      if (state_q == GRANT &&
          grant_idx_q == GNT_IDX_WIDTH'(m)) begin
        owner_cyc     = i_m_wb_cyc[m];
        o_s_wb_stb    = i_m_wb_stb[m];
        o_s_wb_we     = i_m_wb_we[m];
        o_s_wb_cti    = i_m_wb_cti[m*3 +: 3];
        o_s_wb_bte    = i_m_wb_bte[m*2 +: 2];
        o_s_wb_sel    = i_m_wb_sel[m*WB_DATA_SIZE +: WB_DATA_SIZE];
        o_s_wb_addr   = i_m_wb_addr[m*OPTN_WB_ADDR_WIDTH +: OPTN_WB_ADDR_WIDTH];
        o_s_wb_data   = i_m_wb_data[m*OPTN_WB_DATA_WIDTH +: OPTN_WB_DATA_WIDTH];
        o_m_wb_ack[m] = i_s_wb_ack;
      end
    end
  end

  assign o_s_wb_cyc    = owner_cyc;
  assign o_m_wb_data   = i_s_wb_data;
  assign o_grant_valid = grant_valid_q;
  assign o_grant_idx   = grant_idx_q;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= win_idx;
          end
        end
        GRANT: begin
          if (!owner_cyc) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_procyon_wb_arbiter.sv
// Directed bench for procyon_wb_arbiter with two masters.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_procyon_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [7:0]  m_sel;
  logic [63:0] m_addr, m_wdata;
  logic [1:0]  m_ack;
  logic [31:0] m_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic        gnt_valid;
  logic [0:0]  gnt_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  procyon_wb_arbiter dut (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .i_m_wb_cyc    (m_cyc),
    .i_m_wb_stb    (m_stb),
    .i_m_wb_we     (m_we),
    .i_m_wb_cti    (m_cti),
    .i_m_wb_bte    (m_bte),
    .i_m_wb_sel    (m_sel),
    .i_m_wb_addr   (m_addr),
    .i_m_wb_data   (m_wdata),
    .o_m_wb_ack    (m_ack),
    .o_m_wb_data   (m_rdata),
    .o_s_wb_cyc    (s_cyc),
    .o_s_wb_stb    (s_stb),
    .o_s_wb_we     (s_we),
    .o_s_wb_cti    (s_cti),
    .o_s_wb_bte    (s_bte),
    .o_s_wb_sel    (s_sel),
    .o_s_wb_addr   (s_addr),
    .o_s_wb_data   (s_wdata),
    .i_s_wb_ack    (s_ack),
    .i_s_wb_data   (s_rdata),
    .o_grant_valid (gnt_valid),
    .o_grant_idx   (gnt_idx)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_cti = '0; m_bte = '0; m_sel = '0;
    m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    m_cyc = 2'b11; m_stb = 2'b11;
    step(); step();
    n_chk++;
    if (gnt_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", gnt_valid);
    else n_pass++;
    n_chk++;
    if (gnt_idx !== 1'b0)
      $display("FAIL rst_idx: got %b want 0", gnt_idx);
    else n_pass++;
    n_chk++;
    if ({s_cyc, s_stb, s_we} !== 3'b000)
      $display("FAIL rst_ctrl: got %b want 000", {s_cyc, s_stb, s_we});
    else n_pass++;
    n_chk++;
    if (m_ack !== 2'b00 || s_addr !== 32'h0)
      $display("FAIL rst_ack_addr: got %b/%h want 00/0", m_ack, s_addr);
    else n_pass++;
    clear_all();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00;
    m_addr[63:32] = 32'h100;
    step();
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 1'b1)
      $display("FAIL rd_grant: got %b/%b want 1/1", gnt_valid, gnt_idx);
    else n_pass++;
    n_chk++;
    if (s_addr !== 32'h100 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b0)
      $display("FAIL rd_slave: got addr %h cyc %b stb %b we %b want 100/1/1/0",
               s_addr, s_cyc, s_stb, s_we);
    else n_pass++;
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (m_ack !== 2'b10 || m_rdata !== 32'hDEADBEEF)
      $display("FAIL rd_ack: got %b/%h want 10/deadbeef", m_ack, m_rdata);
    else n_pass++;
    step();
    clear_all();
    step();
    n_chk++;
    if (gnt_valid !== 1'b0 || dut.rr_ptr_q !== 1'b0)
      $display("FAIL rd_release: got valid %b ptr %b want 0/0",
               gnt_valid, dut.rr_ptr_q);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_addr = {32'h20, 32'h10};
    step();
    s_ack = 1'b1;
    #1;
    n_chk++;
    if (gnt_idx !== 1'b0 || s_addr !== 32'h10 || m_ack !== 2'b01)
      $display("FAIL sim_first: got idx %b addr %h ack %b want 0/10/01",
               gnt_idx, s_addr, m_ack);
    else n_pass++;
    step();
    s_ack = 1'b0;
    m_cyc = 2'b10; m_stb = 2'b10;
    #1;
    n_chk++;
    if (s_cyc !== 1'b0)
      $display("FAIL sim_drop_cyc: got %b want 0", s_cyc);
    else n_pass++;
    step();
    n_chk++;
    if (gnt_valid !== 1'b0 || m_ack !== 2'b00 || s_cyc !== 1'b0)
      $display("FAIL sim_dead: got valid %b ack %b cyc %b want 0/00/0",
               gnt_valid, m_ack, s_cyc);
    else n_pass++;
    step();
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 1'b1 || s_addr !== 32'h20)
      $display("FAIL sim_second: got %b/%b/%h want 1/1/20",
               gnt_valid, gnt_idx, s_addr);
    else n_pass++;
    clear_all();
    step();
  endtask

  task automatic test_fairness();
    logic [0:0] exp_idx;
    logic [0:0] exp_ptr;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_idx = t[0:0];
      exp_ptr = ~exp_idx;
      step();
      s_ack = 1'b1;
      #1;
      n_chk++;
      if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx ||
          m_ack !== (2'b01 << exp_idx))
        $display("FAIL fair_grant%0d: got %b/%b ack %b want 1/%b",
                 t, gnt_valid, gnt_idx, m_ack, exp_idx);
      else n_pass++;
      step();
      s_ack = 1'b0;
      m_cyc[exp_idx] = 1'b0;
      step();
      n_chk++;
      if (gnt_valid !== 1'b0 || dut.rr_ptr_q !== exp_ptr)
        $display("FAIL fair_ptr%0d: got valid %b ptr %b want 0/%b",
                 t, gnt_valid, dut.rr_ptr_q, exp_ptr);
      else n_pass++;
      m_cyc[exp_idx] = 1'b1;
    end
    clear_all();
    step();
  endtask

  task automatic test_burst();
    int bad;
    bad = 0;
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_cti[5:3] = 3'b010;
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_addr[31:0] = 32'h500;
    for (int b = 0; b < 8; b++) begin
      m_cti[5:3] = (b == 7) ? 3'b111 : 3'b010;
      m_addr[63:32] = 32'h200 + 32'(b * 4);
      m_wdata[63:32] = 32'hA000 + 32'(b);
      s_ack = 1'b1;
      #1;
      if (m_ack !== 2'b10 || gnt_idx !== 1'b1 || s_we !== 1'b1 ||
          s_cti !== m_cti[5:3] || s_addr !== 32'h200 + 32'(b * 4) ||
          s_wdata !== 32'hA000 + 32'(b))
        bad++;
      step();
    end
    n_chk++;
    if (bad !== 0)
      $display("FAIL burst_beats: got %0d bad beats want 0", bad);
    else n_pass++;
    s_ack = 1'b0;
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b00;
    step();
    n_chk++;
    if (gnt_valid !== 1'b0)
      $display("FAIL burst_dead: got %b want 0", gnt_valid);
    else n_pass++;
    step();
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 1'b0 || s_addr !== 32'h500)
      $display("FAIL burst_next: got %b/%b/%h want 1/0/500",
               gnt_valid, gnt_idx, s_addr);
    else n_pass++;
    clear_all();
    step();
  endtask

  task automatic test_ack_isolation();
    int bad;
    bad = 0;
    m_cyc = 2'b01; m_stb = 2'b01;
    m_addr = {32'h400, 32'h300};
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1;
      #1;
      if (m_ack !== 2'b01 || s_addr !== 32'h300 || gnt_idx !== 1'b0)
        bad++;
      step();
    end
    n_chk++;
    if (bad !== 0)
      $display("FAIL iso_beats: got %0d bad beats want 0", bad);
    else n_pass++;
    clear_all();
    step();
    step();
  endtask

  task automatic test_reset_mid_burst();
    m_cyc = 2'b10; m_stb = 2'b10;
    m_cti[5:3] = 3'b010;
    m_addr[63:32] = 32'h600;
    step();
    s_ack = 1'b1;
    step(); step();
    rst = 1'b1;
    #1;
    n_chk++;
    if (s_cyc !== 1'b0 || gnt_valid !== 1'b0 || m_ack !== 2'b00)
      $display("FAIL rstmid_drop: got cyc %b valid %b ack %b want 0/0/00",
               s_cyc, gnt_valid, m_ack);
    else n_pass++;
    step();
    clear_all();
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 1'b0)
      $display("FAIL rstmid_ptr: got %b/%b want 1/0", gnt_valid, gnt_idx);
    else n_pass++;
    m_cyc = 2'b10; m_stb = 2'b10;
    step(); step();
    n_chk++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 1'b1)
      $display("FAIL rstmid_m1: got %b/%b want 1/1", gnt_valid, gnt_idx);
    else n_pass++;
    clear_all();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_burst();
    test_ack_isolation();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
